uart_rx_oversample: RTL and testbench

Standalone oversampling UART receiver: the receive end of the team's 8N1/8E1 serial link. It recovers frames from an asynchronous serial line using an N× oversampling clock and presents parallel data with a one-cycle valid strobe. It uses the same frame format and parameters as the transmit path of the UART device, so it can terminate that device's `tx_out` on a separate board-level or loopback link. Parity and stop errors are reported per frame.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_oversample_if.sv | 11 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_rx_oversample.sv | 93 +++++++++
 tb/tb_uart_rx_oversample.sv | 118 +++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity encodings and parity helper for the RX and TX paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  function automatic logic calc_parity(input logic [63:0] data, input logic par_type);
    return (^data) ^ par_type;
  endfunction
endpackage

// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if: serial line in, parallel frame results out
interface uart_rx_oversample_if #(parameter int DATA_WIDTH = 8);
  logic RX_IN;
  logic [DATA_WIDTH-1:0] P_DATA_OUT;
  logic DATA_VALID;
  logic parity_error;
  logic stop_error;
  logic busy;
  modport master (output RX_IN, input P_DATA_OUT, DATA_VALID, parity_error, stop_error, busy);
  modport slave (input RX_IN, output P_DATA_OUT, DATA_VALID, parity_error, stop_error, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer plus previous-sample register with falling-edge pulse
module uart_rx_sync (
  input  logic rx_clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_sync,
  output logic o_fall
);
  logic r_s1, r_s2, r_prev;
  // line idles high, so every stage resets to 1 to avoid a fake edge after reset
  always_ff @(posedge rx_clk)
    if (rst) {r_s1, r_s2, r_prev} <= 3'b111;
    else {r_s1, r_s2, r_prev} <= {i_rx, r_s1, r_s2};
  assign o_sync = r_s2;
  assign o_fall = r_prev & ~r_s2;
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: N-times oversampling UART receiver; define UART_RX_MAJORITY_EN for 3-sample majority voting
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_EN = 1,
  parameter int PAR_TYPE = 0,
  parameter int N = 4
) (
  input logic rx_clk,
  input logic rst,
  uart_rx_oversample_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [PW-1:0] C_MID = PW'(N / 2);
  localparam logic [PW-1:0] C_DEC = PW'(N / 2 + 1);
  localparam logic [PW-1:0] C_LAST = PW'(N - 1);
  rx_state_t r_state, w_next;
  logic [PW-1:0] r_phase;
  logic [IW-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_shift, r_data;
  logic r_v1, r_par_err, r_valid, r_perr, r_serr, r_busy;
  logic w_sync, w_fall, w_dec, w_bit, w_last;
  logic w_valid, w_perr, w_serr, w_done;
  uart_rx_sync u_sync (.rx_clk(rx_clk), .rst(rst), .i_rx(bus.RX_IN), .o_sync(w_sync), .o_fall(w_fall));
  assign w_dec = r_phase == C_DEC;
  assign w_last = r_idx == IW'(DATA_WIDTH - 1);
  // center sample of each bit, held until the decision point one cycle later
  always_ff @(posedge rx_clk)
    if (r_phase == C_MID) r_v1 <= w_sync;
`ifdef UART_RX_MAJORITY_EN
  logic r_v0;
  // early sample for the vote; the late sample is the live synced bit at the decision
  always_ff @(posedge rx_clk)
    if (r_phase == PW'(N / 2 - 1)) r_v0 <= w_sync;
  assign w_bit = (r_v0 & r_v1) | (r_v0 & w_sync) | (r_v1 & w_sync);
`else
  assign w_bit = r_v1;
`endif
  // state register
  always_ff @(posedge rx_clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state: every bit is resolved at its decision phase
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fall ? START : IDLE;
      START:   w_next = w_dec ? (w_bit ? IDLE : DATA) : START;
      DATA:    w_next = (w_dec && w_last) ? (PAR_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_dec ? STOP : PARITY;
      STOP:    w_next = w_dec ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // bit phase, data shift and parity check; counters park at start values while idle
  always_ff @(posedge rx_clk)
    if (rst || r_state == IDLE) begin
      r_phase <= PW'(1);
      r_idx <= '0;
      r_par_err <= 1'b0;
    end else begin
      r_phase <= r_phase == C_LAST ? '0 : r_phase + 1'b1;
      if (r_state == DATA && w_dec) begin
        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == PARITY && w_dec) r_par_err <= w_bit != calc_parity(64'(r_shift), PAR_TYPE[0]);
    end
  // frame outcome at the stop decision
  always_comb begin
    w_done = r_state == STOP && w_dec;
    w_valid = w_done && w_bit && !r_par_err;
    w_perr = w_done && r_par_err;
    w_serr = w_done && !w_bit;
  end
  // registered outputs; data is loaded on every completed frame, even a bad one
  always_ff @(posedge rx_clk)
    if (rst) begin
      r_data <= '0;
      {r_valid, r_perr, r_serr, r_busy} <= 4'b0;
    end else begin
      if (w_done) r_data <= r_shift;
      {r_valid, r_perr, r_serr} <= {w_valid, w_perr, w_serr};
      r_busy <= w_next != IDLE;
    end
  assign bus.P_DATA_OUT = r_data;
  assign bus.DATA_VALID = r_valid;
  assign bus.parity_error = r_perr;
  assign bus.stop_error = r_serr;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed frames with a scoreboard checked by an independent strobe monitor
module tb_uart_rx_oversample;
  localparam int N = 4;
  localparam int LAT = 2 + 10 * N + N / 2 + 2;
  typedef struct {
    logic [7:0] d;
    logic v, pe, se;
    int at;
  } exp_t;
  logic rx_clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  exp_t sb[$];
  uart_rx_oversample_if #(.DATA_WIDTH(8)) bus ();
  uart_rx_oversample #(.DATA_WIDTH(8), .PAR_EN(1), .PAR_TYPE(0), .N(N)) dut (
    .rx_clk(rx_clk), .rst(rst), .bus(bus)
  );
  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive(input logic b);
    @(posedge rx_clk);
    #1 bus.RX_IN = b;
  endtask
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int glitch, input int abort_k,
                      input bit push, input logic [7:0] ed, input logic ev, input logic epe, input logic ese);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    for (int k = 0; k < 11 && k != abort_k; k++)
      for (int j = 0; j < N; j++) begin
        drive(fr[k] ^ (k * N + j == glitch));
        if (k == 0 && j == 0 && push) sb.push_back('{d: ed, v: ev, pe: epe, se: ese, at: cyc + LAT});
      end
  endtask
  initial forever begin
    @(negedge rx_clk);
    if (bus.DATA_VALID || bus.parity_error || bus.stop_error) begin
      if (sb.size() == 0)
        check("spurious_strobe", 32'({bus.DATA_VALID, bus.parity_error, bus.stop_error}), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 32'(bus.P_DATA_OUT), 32'(e.d));
        check("sb_flags", 32'({bus.DATA_VALID, bus.parity_error, bus.stop_error}), 32'({e.v, e.pe, e.se}));
        check("sb_time", 32'(cyc), 32'(e.at));
      end
    end
  end
  initial begin
    int t;
    bus.RX_IN = 1'b1;
    repeat (3) @(posedge rx_clk);
    #1 rst = 1'b0;
    @(negedge rx_clk);
    check("reset_data", 32'(bus.P_DATA_OUT), 32'h0);
    check("reset_flags", 32'({bus.DATA_VALID, bus.parity_error, bus.stop_error}), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    send(8'hA5, 1'b0, 1'b1, -1, -1, 1, 8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b1);
    @(negedge rx_clk);
    check("data_hold", 32'(bus.P_DATA_OUT), 32'hA5);
    send(8'hA5, 1'b1, 1'b1, -1, -1, 1, 8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (8) drive(1'b1);
    send(8'h3C, 1'b0, 1'b0, -1, -1, 1, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (20) drive(1'b0);
    @(negedge rx_clk);
    check("no_start_while_low", 32'(bus.busy), 32'h0);
    repeat (8) drive(1'b1);
    @(negedge rx_clk);
    check("no_start_on_rise", 32'(bus.busy), 32'h0);
    send(8'h5A, 1'b0, 1'b1, -1, -1, 1, 8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b1);
    drive(1'b0);
    t = cyc;
    drive(1'b1);
    @(posedge rx_clk);
    @(posedge rx_clk);
    @(negedge rx_clk);
    check("glitch_busy_rise", 32'(cyc - t), 32'd3);
    check("glitch_busy_high", 32'(bus.busy), 32'h1);
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    check("glitch_busy_fall", 32'(bus.busy), 32'h0);
    repeat (4) drive(1'b1);
`ifdef UART_RX_MAJORITY_EN
    send(8'h00, 1'b0, 1'b1, 6, -1, 1, 8'h00, 1'b1, 1'b0, 1'b0);
`else
    send(8'h00, 1'b0, 1'b1, 6, -1, 1, 8'h01, 1'b0, 1'b1, 1'b0);
`endif
    repeat (8) drive(1'b1);
    send(8'h00, 1'b0, 1'b1, -1, -1, 1, 8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1, -1, -1, 1, 8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (8) drive(1'b1);
    send(8'h55, 1'b0, 1'b1, -1, 5, 0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge rx_clk);
    #1 rst = 1'b1;
    bus.RX_IN = 1'b1;
    @(posedge rx_clk);
    #1 rst = 1'b0;
    @(negedge rx_clk);
    check("midframe_rst_busy", 32'(bus.busy), 32'h0);
    check("midframe_rst_data", 32'(bus.P_DATA_OUT), 32'h0);
    check("midframe_rst_flags", 32'({bus.DATA_VALID, bus.parity_error, bus.stop_error}), 32'h0);
    repeat (4) drive(1'b1);
    send(8'h12, 1'b0, 1'b1, -1, -1, 1, 8'h12, 1'b1, 1'b0, 1'b0);
    repeat (60) drive(1'b1);
    @(negedge rx_clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
